// File: rtl/agmii_tx_arbiter.sv
// ---------------------------------------------------------------------------
// agmii_tx_arbiter
//
// Shares the single AGMII transmit path between two packet sources. Whole
// frames are granted round-robin. The granted byte stream is forwarded with
// one cycle of registered latency. A minimum inter-frame gap is enforced,
// and runaway frames are cut at MAX_LEN strobed bytes.
//
// Ports (all in the agmii_clk domain):
//   clk      in   1  agmii_clk, 125 MHz
//   rst_n    in   1  asynchronous active-low reset, synchronous release
//   req0     in   1  requester 0 frame request (level)
//   d0       in   8  requester 0 data
//   s0       in   1  requester 0 strobe; one contiguous high run = one frame
//   grant0   out  1  requester 0 owns the Tx path
//   req1/d1/s1/grant1  same for requester 1
//   tx_d     out  8  data to AGMII Tx (zero whenever tx_s is low)
//   tx_s     out  1  strobe to AGMII Tx
//   trunc    out  1  one-cycle pulse: frame cut at MAX_LEN
//   timeout  out  1  one-cycle pulse: grant revoked after START_TO idle cycles
//   busy     out  1  arbiter is not idle
// ---------------------------------------------------------------------------
module agmii_tx_arbiter #(
  parameter int IPG      = 12,    // 1..255 idle cycles between frames
  parameter int MAX_LEN  = 1530,  // 64..4095 bytes per frame
  parameter int START_TO = 64     // 1..255 cycles to raise strobe after grant
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] d0,
  input  logic       s0,
  output logic       grant0,
  input  logic       req1,
  input  logic [7:0] d1,
  input  logic       s1,
  output logic       grant1,
  output logic [7:0] tx_d,
  output logic       tx_s,
  output logic       trunc,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_XMIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [11:0] MAX_LEN_C  = 12'(MAX_LEN);
  localparam logic [7:0]  IPG_C      = 8'(IPG);
  // The timeout fires on the START_TO-th WAIT edge, i.e. when the counter
  // (zeroed on entry) has reached START_TO-1.
  localparam logic [7:0]  TO_LAST_C  = 8'(START_TO - 1);

  state_t      r_state;
  logic        r_sel;
  logic        r_last;
  logic [11:0] r_count;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_wait_cnt;
  logic        r_grant0;
  logic        r_grant1;
  logic [7:0]  r_tx_d;
  logic        r_tx_s;
  logic        r_trunc;
  logic        r_timeout;
  logic        r_busy;

  logic        w_req_sel;
  logic        w_s_sel;
  logic [7:0]  w_d_sel;
  logic        w_pick;

  // Saturating 8-bit increment: gap and wait counters must never wrap.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  assign w_req_sel = r_sel ? req1 : req0;
  assign w_s_sel   = r_sel ? s1   : s0;
  assign w_d_sel   = r_sel ? d1   : d0;
  // On a tie the requester that did not win last time gets the path;
  // with a single requester it simply wins.
  assign w_pick    = (req0 & req1) ? ~r_last : req1;

  // Arbitration FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= 1'b0;
      r_last     <= 1'b1;
      r_count    <= 12'd0;
      r_gap_cnt  <= 8'd0;
      r_wait_cnt <= 8'd0;
      r_grant0   <= 1'b0;
      r_grant1   <= 1'b0;
      r_tx_d     <= 8'd0;
      r_tx_s     <= 1'b0;
      r_trunc    <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_trunc   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req0 | req1) begin
            r_sel      <= w_pick;
            r_last     <= w_pick;
            r_grant0   <= ~w_pick;
            r_grant1   <= w_pick;
            r_wait_cnt <= 8'd0;
            r_busy     <= 1'b1;
            r_state    <= ST_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_WAIT: begin
          if (w_s_sel) begin
            r_tx_d  <= w_d_sel;
            r_tx_s  <= 1'b1;
            r_count <= 12'd1;
            r_state <= ST_XMIT;
          end else if (!w_req_sel) begin
            // Withdrawn before any byte was sent: no gap is owed.
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (r_wait_cnt >= TO_LAST_C) begin
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
            r_timeout <= 1'b1;
            r_gap_cnt <= 8'd1;
            r_state   <= ST_GAP;
          end else begin
            r_wait_cnt <= sat_inc8(r_wait_cnt);
          end
        end

        ST_XMIT: begin
          if (w_s_sel) begin
            if (r_count < MAX_LEN_C) begin
              r_tx_d  <= w_d_sel;
              r_count <= r_count + 12'd1;
            end else begin
              // Cut here; the rest of the source's strobe run is swallowed
              // in DRAIN while the grant is still held.
              r_tx_d    <= 8'd0;
              r_tx_s    <= 1'b0;
              r_trunc   <= 1'b1;
              r_gap_cnt <= 8'd1;
              r_state   <= ST_DRAIN;
            end
          end else begin
            r_tx_d    <= 8'd0;
            r_tx_s    <= 1'b0;
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
            r_gap_cnt <= 8'd1;
            r_state   <= ST_GAP;
          end
        end

        ST_DRAIN: begin
          // tx_s is already low, so these cycles count toward the gap.
          r_gap_cnt <= sat_inc8(r_gap_cnt);
          if (!w_s_sel) begin
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_state  <= ST_GAP;
          end else begin
            r_state <= ST_DRAIN;
          end
        end

        ST_GAP: begin
          if (r_gap_cnt >= IPG_C) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= sat_inc8(r_gap_cnt);
          end
        end

        default: begin
          r_grant0 <= 1'b0;
          r_grant1 <= 1'b0;
          r_tx_d   <= 8'd0;
          r_tx_s   <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant0  = r_grant0;
  assign grant1  = r_grant1;
  assign tx_d    = r_tx_d;
  assign tx_s    = r_tx_s;
  assign trunc   = r_trunc;
  assign timeout = r_timeout;
  assign busy    = r_busy;

endmodule

// File: tb/tb_agmii_tx_arbiter.sv
// Self-checking bench for agmii_tx_arbiter: directed scenarios with literal
// expectations, then two randomized requester agents; a frame-level
// reference model is compared with the DUT outputs on every falling edge.
module tb_agmii_tx_arbiter;

  localparam int P_IPG = 12;
  localparam int P_MAX = 100;
  localparam int P_TO  = 64;

  logic       clk;
  logic       rst_n;
  logic       req0, req1, s0, s1;
  logic [7:0] d0, d1;
  logic       grant0, grant1, tx_s, trunc, timeout, busy;
  logic [7:0] tx_d;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  agmii_tx_arbiter #(.IPG(P_IPG), .MAX_LEN(P_MAX), .START_TO(P_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .d0(d0), .s0(s0), .grant0(grant0),
    .req1(req1), .d1(d1), .s1(s1), .grant1(grant1),
    .tx_d(tx_d), .tx_s(tx_s), .trunc(trunc), .timeout(timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: who owns the path, whether its frame has started,
  // how many bytes went out, whether it was cut, and how long the line
  // has been quiet since the frame ended.
  typedef struct packed {
    bit         has_owner;
    bit         who;
    bit         started;
    bit         cut;
    bit         gap;
    bit         last;
    int         sent;
    int         waited;
    int         low;
    bit         tx_s;
    logic [7:0] tx_d;
    bit         trunc;
    bit         timeout;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mreset();
    mdl_t n;
    n = '0;
    n.last = 1'b1;
    return n;
  endfunction

  function automatic mdl_t mstep(input mdl_t c, input logic r0, input logic r1,
                                 input logic si0, input logic si1,
                                 input logic [7:0] di0, input logic [7:0] di1);
    mdl_t n;
    logic s, rq;
    logic [7:0] d;
    n = c;
    n.trunc = 1'b0; n.timeout = 1'b0; n.tx_s = 1'b0; n.tx_d = 8'h00;
    s  = c.who ? si1 : si0;
    rq = c.who ? r1  : r0;
    d  = c.who ? di1 : di0;
    if (c.has_owner) begin
      if (!c.started) begin
        if (s === 1'b1) begin
          n.started = 1'b1; n.sent = 1; n.tx_s = 1'b1; n.tx_d = d;
        end else if (rq !== 1'b1) begin
          n.has_owner = 1'b0;
        end else if (c.waited + 1 == P_TO) begin
          n.has_owner = 1'b0; n.timeout = 1'b1; n.gap = 1'b1; n.low = 1;
        end else begin
          n.waited = c.waited + 1;
        end
      end else if (c.cut) begin
        n.low = c.low + 1;
        if (s !== 1'b1) begin n.has_owner = 1'b0; n.gap = 1'b1; end
      end else if (s === 1'b1 && c.sent < P_MAX) begin
        n.sent = c.sent + 1; n.tx_s = 1'b1; n.tx_d = d;
      end else if (s === 1'b1) begin
        n.cut = 1'b1; n.trunc = 1'b1; n.low = 1;
      end else begin
        n.has_owner = 1'b0; n.gap = 1'b1; n.low = 1;
      end
    end else if (c.gap) begin
      if (c.low >= P_IPG) n.gap = 1'b0;
      else n.low = c.low + 1;
    end else if (r0 === 1'b1 || r1 === 1'b1) begin
      n.has_owner = 1'b1;
      n.who = (r0 === 1'b1 && r1 === 1'b1) ? ~c.last : (r1 === 1'b1);
      n.last = n.who; n.started = 1'b0; n.cut = 1'b0; n.waited = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mreset();
    else m <= mstep(m, req0, req1, s0, s1, d0, d1);
  end

  // Single compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("grant0",  32'(grant0),  32'(m.has_owner && !m.who));
      check("grant1",  32'(grant1),  32'(m.has_owner && m.who));
      check("tx_s",    32'(tx_s),    32'(m.tx_s));
      check("tx_d",    32'(tx_d),    32'(m.tx_d));
      check("trunc",   32'(trunc),   32'(m.trunc));
      check("timeout", 32'(timeout), 32'(m.timeout));
      check("busy",    32'(busy),    32'(m.has_owner || m.gap));
    end
  end

  // ---------------- directed helpers ----------------
  int hi_cnt, trunc_cnt, to_cnt, g0_cnt, min_gap, cur_low;
  bit seen_frame, prev_txs;
  logic [7:0] first_b, last_b;
  int order_q[$];

  task automatic clear_stats();
    hi_cnt = 0; trunc_cnt = 0; to_cnt = 0; g0_cnt = 0; min_gap = 9999;
    cur_low = 0; seen_frame = 1'b0; order_q.delete();
  endtask

  task automatic step();
    @(negedge clk);
    if (tx_s === 1'b1) begin
      if (!prev_txs) begin
        if (seen_frame && cur_low < min_gap) min_gap = cur_low;
        seen_frame = 1'b1;
        order_q.push_back((grant1 === 1'b1) ? 1 : 0);
        first_b = tx_d;
      end
      hi_cnt++; last_b = tx_d; cur_low = 0;
    end else begin
      cur_low++;
    end
    prev_txs = (tx_s === 1'b1);
    if (trunc === 1'b1) trunc_cnt++;
    if (timeout === 1'b1) to_cnt++;
    if (grant0 === 1'b1) g0_cnt++;
  endtask

  task automatic set_in(input int who, input logic r, input logic s, input logic [7:0] d);
    if (who == 0) begin req0 = r; s0 = s; d0 = d; end
    else begin req1 = r; s1 = s; d1 = d; end
  endtask

  function automatic logic my_grant(input int who);
    return (who == 0) ? grant0 : grant1;
  endfunction

  task automatic wait_grant(input int who);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (my_grant(who) === 1'b1) begin ok = 1'b1; break; end
      step();
    end
    check("grant_wait", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
    check("idle_wait", 32'(ok), 32'd1);
  endtask

  // Byte i is driven at the i-th falling edge after the grant is seen.
  task automatic send_frame(input int who, input int n);
    for (int i = 0; i < n; i++) begin
      set_in(who, 1'b1, 1'b1, 8'(i));
      step();
    end
    set_in(who, (who == 0) ? req0 : req1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b0, 8'h00);
    set_in(1, 1'b0, 1'b0, 8'h00);
    step(); step();
    rst_n = 1'b1;
  endtask

  // ---------------- random agent ----------------
  task automatic agent(input int who);
    int choice, len;
    bit ok;
    logic rq;
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 15)) begin
        set_in(who, 1'b0, ($urandom_range(0, 3) == 0), 8'($urandom));
        @(negedge clk);
      end
      ok = 1'b0;
      for (int k = 0; k < 1000; k++) begin
        if (my_grant(who) === 1'b1) begin ok = 1'b1; break; end
        set_in(who, 1'b1, ($urandom_range(0, 3) == 0), 8'($urandom));
        @(negedge clk);
      end
      check("agent_grant", 32'(ok), 32'd1);
      if (!ok) return;
      choice = $urandom_range(0, 9);
      if (choice == 0) begin
        set_in(who, 1'b0, 1'b0, 8'($urandom));
      end else if (choice == 1) begin
        set_in(who, 1'b1, 1'b0, 8'($urandom));
      end else begin
        len = $urandom_range(1, 140);
        rq  = 1'b1;
        repeat ($urandom_range(0, 4)) begin
          set_in(who, 1'b1, 1'b0, 8'($urandom));
          @(negedge clk);
        end
        for (int k = 0; k < len; k++) begin
          if ($urandom_range(0, 15) == 0) rq = 1'b0;
          set_in(who, rq, 1'b1, 8'($urandom));
          @(negedge clk);
        end
        set_in(who, 1'($urandom_range(0, 1)), 1'b0, 8'($urandom));
      end
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
        if (my_grant(who) !== 1'b1) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      check("agent_release", 32'(ok), 32'd1);
    end
    set_in(who, 1'b0, 1'b0, 8'h00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b0, 8'h00);
    set_in(1, 1'b0, 1'b0, 8'h00);
    prev_txs = 1'b0;
    clear_stats();
    repeat (2) @(negedge clk);
    check("rst_grant0", 32'(grant0), 32'd0);
    check("rst_grant1", 32'(grant1), 32'd0);
    check("rst_tx_s",   32'(tx_s),   32'd0);
    check("rst_tx_d",   32'(tx_d),   32'd0);
    check("rst_busy",   32'(busy),   32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();

    // Single 60-byte frame from requester 0.
    req0 = 1'b1;
    wait_grant(0);
    clear_stats();
    send_frame(0, 60);
    req0 = 1'b0;
    step();
    check("single_len",   32'(hi_cnt),  32'd60);
    check("single_first", 32'(first_b), 32'h00);
    check("single_last",  32'(last_b),  32'h3B);
    check("single_g0_drop", 32'(grant0), 32'd0);
    repeat (11) step();
    check("single_busy_gap", 32'(busy), 32'd1);
    step();
    check("single_busy_end", 32'(busy), 32'd0);

    // Contention from reset: 0,1,0,1 with at least IPG quiet cycles between.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    clear_stats();
    for (int f = 0; f < 4; f++) begin
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
        if (grant0 === 1'b1 || grant1 === 1'b1) begin ok = 1'b1; break; end
        step();
      end
      check("cont_grant", 32'(ok), 32'd1);
      send_frame((grant1 === 1'b1) ? 1 : 0, 64);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_idle();
    check("cont_frames", 32'(order_q.size()), 32'd4);
    for (int f = 0; f < order_q.size(); f++) check("cont_order", 32'(order_q[f]), 32'(f % 2));
    check("cont_gap_ge_ipg", 32'(min_gap >= P_IPG), 32'd1);

    // Truncation: 150-byte strobe run against MAX_LEN=100.
    req1 = 1'b1;
    wait_grant(1);
    clear_stats();
    send_frame(1, 150);
    check("trunc_g1_held", 32'(grant1), 32'd1);
    req1 = 1'b0;
    step();
    check("trunc_len",     32'(hi_cnt),    32'd100);
    check("trunc_pulses",  32'(trunc_cnt), 32'd1);
    check("trunc_g1_drop", 32'(grant1),    32'd0);
    check("trunc_gap",     32'(busy),      32'd1);
    wait_idle();

    // Start timeout: requester 0 never strobes, requester 1 waits behind it.
    clear_stats();
    req0 = 1'b1;
    wait_grant(0);
    req1 = 1'b1;
    for (int k = 0; k < 200 && to_cnt == 0; k++) step();
    check("to_g0_cycles", 32'(g0_cnt), 32'd64);
    check("to_pulses",    32'(to_cnt), 32'd1);
    begin
      int t;
      t = 0;
      for (int k = 0; k < 200 && grant1 !== 1'b1; k++) begin step(); t++; end
      check("to_next_grant_delay", 32'(t), 32'd13);
    end
    req0 = 1'b0;
    send_frame(1, 10);
    req1 = 1'b0;
    step();
    wait_idle();
    check("to_pulse_once", 32'(to_cnt), 32'd1);

    // Withdrawal before strobe: no gap, pending requester 1 follows at once.
    req0 = 1'b1;
    wait_grant(0);
    req0 = 1'b0; req1 = 1'b1;
    step();
    check("wd_g0_drop", 32'(grant0), 32'd0);
    check("wd_no_gap",  32'(busy),   32'd0);
    step();
    check("wd_g1_next", 32'(grant1), 32'd1);
    req1 = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a frame.
    req0 = 1'b1;
    wait_grant(0);
    for (int i = 0; i < 30; i++) begin
      set_in(0, 1'b1, 1'b1, 8'(i + 100));
      step();
    end
    check("mid_pre_txs", 32'(tx_s), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_txs",   32'(tx_s),   32'd0);
    check("mid_rst_txd",   32'(tx_d),   32'd0);
    check("mid_rst_grant", 32'(grant0), 32'd0);
    check("mid_rst_busy",  32'(busy),   32'd0);
    set_in(0, 1'b0, 1'b0, 8'h00);
    step(); step();
    rst_n = 1'b1;
    clear_stats();
    req1 = 1'b1;
    wait_grant(1);
    send_frame(1, 20);
    req1 = 1'b0;
    step();
    wait_idle();
    check("mid_after_len", 32'(hi_cnt), 32'd20);
    check("mid_after_frames", 32'(order_q.size()), 32'd1);
    if (order_q.size() > 0) check("mid_after_owner", 32'(order_q[0]), 32'd1);

    // Randomized traffic from both requesters at once.
    fork
      agent(0);
      agent(1);
    join
    repeat (200) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
